// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder: anode codes,
// cathode patterns (bit 0 = segment a), FSM state type and BCD-to-binary helper.
package seg7_pkg;

  localparam logic [3:0] ANODE_D0    = 4'b1110;
  localparam logic [3:0] ANODE_D1    = 4'b1101;
  localparam logic [3:0] ANODE_D2    = 4'b1011;
  localparam logic [3:0] ANODE_BLANK = 4'b1111;

  // Active-low cathodes written a..g left to right, so index 0 is segment a
  localparam logic [0:6] SEG_0 = 7'b0000001;
  localparam logic [0:6] SEG_1 = 7'b1001111;
  localparam logic [0:6] SEG_2 = 7'b0010010;
  localparam logic [0:6] SEG_3 = 7'b0000110;
  localparam logic [0:6] SEG_4 = 7'b1001100;
  localparam logic [0:6] SEG_5 = 7'b0100100;
  localparam logic [0:6] SEG_6 = 7'b0100000;
  localparam logic [0:6] SEG_7 = 7'b0001111;
  localparam logic [0:6] SEG_8 = 7'b0000000;
  localparam logic [0:6] SEG_9 = 7'b0000100;

  typedef enum logic [1:0] {
    WAIT_D0,
    GOT_D0,
    GOT_D1
  } scanState_t;

  // Shift-add form of d2*100 + d1*10 + d0; digits are at most 9 so the sum fits
  function automatic logic [9:0] digitsToValue(input logic [3:0] d2,
                                               input logic [3:0] d1,
                                               input logic [3:0] d0);
    logic [9:0] h, t, o;
    h = {6'd0, d2};
    t = {6'd0, d1};
    o = {6'd0, d0};
    return (h << 6) + (h << 5) + (h << 2) + (t << 3) + (t << 1) + o;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-low a..g cathode pattern to a decimal
// digit plus a flag saying whether the pattern is one of the ten digit shapes.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [0:6] seg_i,
  output logic [3:0] digit_o,
  output logic       valid_o
);

  always_comb begin
    digit_o = 4'd0;
    valid_o = 1'b1;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the 0..999 number shown on a multiplexed 3-digit 7-segment display
// by watching its anode/cathode lines, sampling each digit once it has settled.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000  // must be at least 2
) (
  input  logic       clk_100Mhz,
  input  logic       reset_out,
  input  logic [3:0] anode_in,
  input  logic [0:6] seg_in,
  input  logic       clear_err,
  output logic [9:0] value,
  output logic       value_valid,
  output logic       err_flag
);

  localparam int              CW         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   SETTLE_MAX = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]   SAMPLE_AT  = CW'(SETTLE_CYCLES - 1);

  logic [10:0]   sync1_q, sync2_q, prev_q;
  logic [CW-1:0] stableCount_q, stableCount_d;
  logic          sampleStrobe;
  logic [3:0]    sampledAnode;
  logic [0:6]    sampledSeg;
  logic [3:0]    digit;
  logic          digitOk;
  logic          anodeOk;

  scanState_t    state_q;
  logic [3:0]    d0_q, d1_q;
  logic [9:0]    value_q;
  logic          valueValid_q;
  logic          errFlag_q;

  // Display lines are asynchronous to us; prev_q holds last cycle's synchronized word
  always_ff @(posedge clk_100Mhz or posedge reset_out) begin
    if (reset_out) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= {anode_in, seg_in};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    stableCount_d = stableCount_q;
    if (sync2_q != prev_q) begin
      stableCount_d = '0;
    end else if (stableCount_q != SETTLE_MAX) begin
      stableCount_d = stableCount_q + CW'(1);
    end
  end

  always_ff @(posedge clk_100Mhz or posedge reset_out) begin
    if (reset_out) begin
      stableCount_q <= '0;
    end else begin
      stableCount_q <= stableCount_d;
    end
  end

  // Saturation above SAMPLE_AT guarantees a single strobe per stable interval
  assign sampleStrobe = (stableCount_q == SAMPLE_AT);
  assign sampledAnode = prev_q[10:7];
  assign sampledSeg   = prev_q[6:0];
  assign anodeOk      = (sampledAnode == ANODE_D0) || (sampledAnode == ANODE_D1) ||
                        (sampledAnode == ANODE_D2);

  seg7_pattern_decode u_decode (
    .seg_i   (sampledSeg),
    .digit_o (digit),
    .valid_o (digitOk)
  );

  // Frame assembly: ones, then tens, then hundreds; a new error beats clear_err
  always_ff @(posedge clk_100Mhz or posedge reset_out) begin
    if (reset_out) begin
      state_q      <= WAIT_D0;
      d0_q         <= 4'd0;
      d1_q         <= 4'd0;
      value_q      <= 10'd0;
      valueValid_q <= 1'b0;
      errFlag_q    <= 1'b0;
    end else begin
      valueValid_q <= 1'b0;
      if (clear_err) begin
        errFlag_q <= 1'b0;
      end
      if (sampleStrobe && (sampledAnode != ANODE_BLANK)) begin
        if (!anodeOk || !digitOk) begin
          errFlag_q <= 1'b1;
          state_q   <= WAIT_D0;
        end else if (sampledAnode == ANODE_D0) begin
          d0_q    <= digit;
          state_q <= GOT_D0;
        end else if (sampledAnode == ANODE_D1) begin
          if (state_q == GOT_D0) begin
            d1_q    <= digit;
            state_q <= GOT_D1;
          end else begin
            state_q <= WAIT_D0;
          end
        end else begin
          if (state_q == GOT_D1) begin
            value_q      <= digitsToValue(digit, d1_q, d0_q);
            valueValid_q <= 1'b1;
          end
          state_q <= WAIT_D0;
        end
      end
    end
  end

  assign value       = value_q;
  assign value_valid = valueValid_q;
  assign err_flag    = errFlag_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed display scans followed by random scans,
// compared against a digit-collection model of the display protocol.
module tb_seg7_scan_decoder;

  localparam int S = 8;

  logic       clk_100Mhz = 1'b0;
  logic       reset_out;
  logic [3:0] anode_in;
  logic [0:6] seg_in;
  logic       clear_err;
  logic [9:0] value;
  logic       value_valid;
  logic       err_flag;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;
  logic prevValid = 1'b0;

  logic [0:6] segPat [10];
  int  mDigits [3];
  int  mHave;
  int  mValue;
  int  mPulses = 0;
  bit  mErr;
  int  scanPos = 0;
  logic [10:0] lastKey;

  seg7_scan_decoder #(.SETTLE_CYCLES(S)) dut (
    .clk_100Mhz  (clk_100Mhz),
    .reset_out   (reset_out),
    .anode_in    (anode_in),
    .seg_in      (seg_in),
    .clear_err   (clear_err),
    .value       (value),
    .value_valid (value_valid),
    .err_flag    (err_flag)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  // Counts value_valid pulses and insists each one lasts a single cycle
  always @(negedge clk_100Mhz) begin
    if (value_valid === 1'b1) begin
      pulseCount++;
      checks++;
      assert (prevValid === 1'b0) else begin
        errors++;
        $error("FAIL pulse_width: observed value_valid high on consecutive cycles, expected single-cycle pulse");
      end
    end
    prevValid = value_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_value"}, {22'd0, value}, mValue);
    checkOutput({tag, "_err"}, {31'd0, err_flag}, {31'd0, mErr});
    checkOutput({tag, "_pulses"}, pulseCount, mPulses);
  endtask

  function automatic int segToDigit(input logic [0:6] sg);
    for (int i = 0; i < 10; i++) begin
      if (segPat[i] == sg) return i;
    end
    return -1;
  endfunction

  function automatic int anodeToPos(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b1111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] posAnode(input int pos);
    case (pos)
      0:       return 4'b1110;
      1:       return 4'b1101;
      default: return 4'b1011;
    endcase
  endfunction

  // mHave = how many in-order digits (ones, tens) have been collected so far
  task automatic modelSample(input logic [3:0] an, input logic [0:6] sg, output bit errSet);
    int pos, dig;
    errSet = 1'b0;
    pos = anodeToPos(an);
    dig = segToDigit(sg);
    if (pos == 3) return;
    if (pos < 0 || dig < 0) begin
      mErr = 1'b1;
      errSet = 1'b1;
      mHave = 0;
      return;
    end
    if (pos == 0) begin
      mDigits[0] = dig;
      mHave = 1;
    end else if (pos == mHave) begin
      mDigits[pos] = dig;
      if (pos == 2) begin
        mValue = mDigits[2] * 100 + mDigits[1] * 10 + mDigits[0];
        mPulses++;
        mHave = 0;
      end else begin
        mHave = 2;
      end
    end else begin
      mHave = 0;
    end
  endtask

  // Hold one display word for 'hold' cycles; clear_err pulses at negedge clrAt (0 = none).
  // A word held S or more cycles is sampled; its effect lands on clock edge 3+S.
  task automatic applyStimulus(input logic [3:0] an, input logic [0:6] sg, input int hold,
                               input int clrAt, input string tag);
    bit errSet;
    bit sampled;
    anode_in = an;
    seg_in   = sg;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk_100Mhz);
      clear_err = (k == clrAt);
    end
    clear_err = 1'b0;
    #1;
    sampled = (hold >= S);
    errSet  = 1'b0;
    if (clrAt > 0 && (!sampled || clrAt < 2 + S)) mErr = 1'b0;
    if (sampled) modelSample(an, sg, errSet);
    if (clrAt > 0 && sampled && (clrAt > 2 + S || (clrAt == 2 + S && !errSet))) mErr = 1'b0;
    lastKey = {an, sg};
    checkAll(tag);
  endtask

  task automatic applyReset(input string tag);
    anode_in  = 4'b1111;
    seg_in    = 7'b1111111;
    clear_err = 1'b0;
    reset_out = 1'b1;
    repeat (3) @(negedge clk_100Mhz);
    reset_out = 1'b0;
    @(negedge clk_100Mhz);
    #1;
    mHave   = 0;
    mValue  = 0;
    mErr    = 1'b0;
    lastKey = '1;
    checkOutput({tag, "_value"}, {22'd0, value}, 0);
    checkOutput({tag, "_valid"}, {31'd0, value_valid}, 0);
    checkOutput({tag, "_err"}, {31'd0, err_flag}, 0);
  endtask

  task automatic scanDigit(input int pos, input int dig, input string tag);
    applyStimulus(posAnode(pos), segPat[dig], 20, 0, tag);
  endtask

  initial begin
    segPat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    reset_out = 1'b1;
    anode_in  = 4'b1111;
    seg_in    = 7'b1111111;
    clear_err = 1'b0;
    applyReset("reset");

    // Normal frame 7,2,5
    scanDigit(0, 5, "f725_d0");
    scanDigit(1, 2, "f725_d1");
    scanDigit(2, 7, "f725_d2");

    // Tens digit flashes for 5 cycles only
    scanDigit(0, 9, "glitch_d0");
    applyStimulus(4'b1101, segPat[4], 5, 0, "glitch_d1");
    scanDigit(2, 3, "glitch_d2");

    // Bad tens pattern, then 9,0,0 with err still sticky, then clear
    scanDigit(0, 1, "segerr_d0");
    applyStimulus(4'b1101, 7'b1111111, 20, 0, "segerr_d1");
    scanDigit(2, 4, "segerr_d2");
    scanDigit(0, 0, "f900_d0");
    scanDigit(1, 0, "f900_d1");
    scanDigit(2, 9, "f900_d2");
    applyStimulus(4'b1111, 7'b1111111, 12, 1, "clear1");

    // Capture starting mid-scan, then 6,5,4
    scanDigit(1, 2, "mid_d1");
    scanDigit(2, 3, "mid_d2");
    scanDigit(0, 4, "f654_d0");
    scanDigit(1, 5, "f654_d1");
    scanDigit(2, 6, "f654_d2");

    // Two anodes active is an error; all anodes off is ignored
    applyStimulus(4'b1100, segPat[3], 20, 0, "anode1100");
    applyStimulus(4'b1111, 7'b0110110, 20, 0, "blank_seg");
    applyStimulus(4'b1111, 7'b1111111, 12, 1, "clear2");

    // clear_err landing on the same edge as a new error
    applyStimulus(4'b1001, segPat[1], 20, 2 + S, "clr_vs_err");
    applyStimulus(4'b1111, 7'b1111111, 12, 1, "clear3");

    // Reset after tens sampled; lone hundreds afterwards must not complete a frame
    scanDigit(0, 3, "rstmid_d0");
    scanDigit(1, 8, "rstmid_d1");
    applyReset("rstmid");
    scanDigit(2, 1, "rstmid_d2");

    for (int i = 0; i < 80; i++) begin
      logic [3:0] an;
      logic [0:6] sg;
      int hold, clrAt, r;
      do begin
        r = $urandom_range(0, 9);
        if (r <= 6) an = posAnode(scanPos);
        else if (r == 7) an = 4'b1111;
        else if (r == 8) an = 4'($urandom);
        else an = posAnode($urandom_range(0, 2));
        if ($urandom_range(0, 15) == 0) sg = 7'($urandom);
        else sg = segPat[$urandom_range(0, 9)];
      end while ({an, sg} == lastKey);
      if (r <= 6) scanPos = (scanPos + 1) % 3;
      if ($urandom_range(0, 4) == 0) hold = $urandom_range(2, S - 1);
      else hold = $urandom_range(S + 4, S + 12);
      if ($urandom_range(0, 7) == 0) clrAt = $urandom_range(1, hold - 1);
      else clrAt = 0;
      applyStimulus(an, sg, hold, clrAt, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1000: cycles {anode,seg} must be stable before a digit is sampled (min 2).
REQ-002 SHALL have clk_100Mhz  input  1  system clock.
REQ-003 SHALL have reset_out  input  1  reset.
REQ-004 SHALL have anode_in  input  4  active-low digit enables from a multiplexed 3-digit display.
REQ-005 SHALL have seg_in  input  7  active-low cathodes, bit order [0:6] = a..g.
REQ-006 SHALL have clear_err  input  1  synchronous clear of err_flag.
REQ-007 SHALL have value  output  10  last completely decoded frame, binary 0..999.
REQ-008 SHALL have value_valid  output  1  one-cycle pulse when value is updated.
REQ-009 SHALL have err_flag  output  1  sticky frame-error indicator.
REQ-010 SHALL use reset reset_out, asynchronous, active-high; clock clk_100Mhz.

Function
REQ-011 SHALL pass anode_in and seg_in through a 2-flop synchronizer, 11 bits, reset value all-ones.
REQ-012 SHALL count consecutive cycles the synchronized {anode,seg} equals its previous-cycle value; any change clears the count to 0; the count saturates at SETTLE_CYCLES.
REQ-013 SHALL generate exactly one sample strobe per stable interval: the cycle the count first reaches SETTLE_CYCLES-1.
REQ-014 SHALL map anode codes at the sample strobe: 1110 = digit0 (ones), 1101 = digit1 (tens), 1011 = digit2 (hundreds), 1111 = blank (ignored, no error), any other code = anode error.
REQ-015 SHALL decode segments a..g: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9; any other pattern on a valid digit = segment error.
REQ-016 SHALL run FSM states WAIT_D0, GOT_D0, GOT_D1; reset state WAIT_D0.
REQ-017 SHALL move from any state to GOT_D0 on a valid digit0 sample, latching d0.
REQ-018 SHALL move GOT_D0 -> GOT_D1 on a valid digit1 sample, latching d1.
REQ-019 SHALL, in GOT_D1, on a valid digit2 sample, complete the frame and return to WAIT_D0.
REQ-020 SHALL, on an out-of-order valid digit (digit1 outside GOT_D0, digit2 outside GOT_D1), go to WAIT_D0 silently with no error.
REQ-021 SHALL, on an anode or segment error, set err_flag, discard the partial frame and go to WAIT_D0.
REQ-022 SHALL compute value = d2*100 + d1*10 + d0 in 10 bits (no multiplier; shift-add allowed), max 999, with no overflow.
REQ-023 SHALL update value and pulse value_valid high for exactly one cycle, the cycle after the completing digit2 sample.
REQ-024 SHALL hold value between frames.
REQ-025 SHALL clear err_flag on clear_err; when clear_err and a new error coincide, err_flag SHALL remain 1.

Reset
REQ-026 SHALL, on reset_out, set value=0, value_valid=0, err_flag=0, FSM=WAIT_D0, stability count=0, d0/d1/d2=0, synchronizer=all-ones.
REQ-027 SHALL discard a partial frame when reset is asserted mid-frame; no value_valid until a new complete d0,d1,d2 sequence.

Structure
REQ-028 SHALL put the segment pattern constants, anode codes and FSM state type in shared package seg7_pkg.
REQ-029 SHALL place the combinational 7-bit pattern to 4-bit digit-plus-valid lookup in sub-module seg7_pattern_decode.

Verification (bench SETTLE_CYCLES=8, each digit held 20 cycles unless stated)
REQ-030 SHALL check a normal frame: 1110/0100100, 1101/0010010, 1011/0001111 -> value=725, one value_valid pulse, err_flag=0.
REQ-031 SHALL check a glitch: 1101 held only 5 cycles inside a 3,_,9 scan -> no sample, no value_valid for that frame.
REQ-032 SHALL check a segment error: digit1 seg=1111111 -> err_flag=1, no value_valid; next frame 0,0,9 -> value=900 with err_flag still 1; clear_err -> err_flag=0.
REQ-033 SHALL check mid-scan start: first samples are 1101 then 1011 -> ignored, no err; following 4,5,6 frame -> value=654.
REQ-034 SHALL check anode codes: anode 1100 -> err_flag=1; anode 1111 with any seg -> ignored, err_flag unchanged.
REQ-035 SHALL check reset mid-frame: reset pulse after digit1 sampled -> value=0, value_valid=0; a following lone digit2 sample produces no value_valid.
